wm_cycle_controller: RTL and testbench

Parametrised washing-machine cycle controller and successor to the single-coin fixed-sequence controller. Adds a multi-coin credit, internal fill/heat timeout counters, N rinse passes, a lid interlock, fault resume with a retry limit, and a lockout state. It sits between the coin/sensor front-end and the actuator drivers, as a Moore FSM with registered pulse outputs.

---
 rtl/wm_cycle_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : wm_cycle_controller
// Brief    : Washing-machine cycle controller. It is a Moore FSM with
//            multi-coin credit, fill and heat timeouts, N rinse passes, a lid
//            interlock, fault resume with a retry limit, and a lockout state.
// Revision : 1.0 - initial release
// ============================================================================
module wm_cycle_controller #(
    parameter int unsigned COIN_PRICE     = 2,
    parameter int unsigned RINSE_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sig_Coin,
    input  logic       sig_Cancel,
    input  logic       sig_Lid_Closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    input  logic       sig_Out_Of_Balance,
    input  logic       sig_Motor_Failure,
    input  logic       sig_Fault_Ack,
    output logic [3:0] state,
    output logic       ready,
    output logic       fill_Water_Operation,
    output logic       heat_Water_Operation,
    output logic       wash_Operation,
    output logic       rinse_Operation,
    output logic       spin_Operation,
    output logic       fault,
    output logic       lockout,
    output logic       water_Intake,
    output logic       coin_Return,
    output logic       cycle_Done,
    output logic [3:0] credit,
    output logic [3:0] rinse_Count
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_READY   = 4'd1,
        ST_FILL    = 4'd2,
        ST_HEAT    = 4'd3,
        ST_WASH    = 4'd4,
        ST_RINSE   = 4'd5,
        ST_SPIN    = 4'd6,
        ST_FAULT   = 4'd7,
        ST_LOCKOUT = 4'd8
    } state_t;

    localparam logic [3:0]       c_COIN_PRICE   = 4'(COIN_PRICE);
    localparam logic [3:0]       c_RINSE_CYCLES = 4'(RINSE_CYCLES);
    localparam logic [3:0]       c_MAX_RETRIES  = 4'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           r_resume;
    logic [3:0]       r_credit;
    logic [3:0]       r_rinse_cnt;
    logic [3:0]       r_retries;
    logic [CNT_W-1:0] r_timer;
    logic             r_coin_return;
    logic             r_cycle_done;

    state_t           w_state_nxt;
    state_t           w_resume_nxt;
    logic [3:0]       w_credit_nxt;
    logic [3:0]       w_rinse_nxt;
    logic [3:0]       w_retries_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             w_coin_return_nxt;
    logic             w_cycle_done_nxt;
    logic             w_running;
    logic [3:0]       w_credit_inc;
    logic [3:0]       w_rinse_inc;
    logic [3:0]       w_retries_inc;

    // The lid interlock guards every state in which the drum is in use.
    assign w_running     = (r_state == ST_FILL)  || (r_state == ST_HEAT) ||
                           (r_state == ST_WASH)  || (r_state == ST_RINSE) ||
                           (r_state == ST_SPIN);
    assign w_credit_inc  = r_credit + 4'd1;
    assign w_rinse_inc   = r_rinse_cnt + 4'd1;
    assign w_retries_inc = r_retries + 4'd1;

    // Next-state and next-value logic. The timer defaults to zero, so it
    // clears on any state change and only counts while FILL or HEAT waits.
    always_comb begin
        w_state_nxt       = r_state;
        w_resume_nxt      = r_resume;
        w_credit_nxt      = r_credit;
        w_rinse_nxt       = r_rinse_cnt;
        w_retries_nxt     = r_retries;
        w_timer_nxt       = '0;
        w_coin_return_nxt = 1'b0;
        w_cycle_done_nxt  = 1'b0;

        if (w_running && !sig_Lid_Closed) begin
            // An open lid overrides completion and every other condition.
            w_state_nxt  = ST_FAULT;
            w_resume_nxt = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sig_Cancel && (r_credit != 4'd0)) begin
                        // Refunds the held credit together with any coin
                        // arriving in the same cycle.
                        w_coin_return_nxt = 1'b1;
                        w_credit_nxt      = 4'd0;
                    end else if (sig_Coin) begin
                        w_credit_nxt = w_credit_inc;
                        if (w_credit_inc >= c_COIN_PRICE) begin
                            w_credit_nxt = c_COIN_PRICE;
                            w_state_nxt  = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (sig_Cancel) begin
                        w_state_nxt       = ST_IDLE;
                        w_coin_return_nxt = 1'b1;
                        w_credit_nxt      = 4'd0;
                    end else if (sig_Lid_Closed) begin
                        w_state_nxt   = ST_FILL;
                        w_credit_nxt  = 4'd0;
                        w_rinse_nxt   = 4'd0;
                        w_retries_nxt = 4'd0;
                    end
                end
                ST_FILL: begin
                    if (sig_Full) begin
                        w_state_nxt = ST_HEAT;
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        w_state_nxt  = ST_FAULT;
                        w_resume_nxt = ST_FILL;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_HEAT: begin
                    if (sig_Temperature) begin
                        w_state_nxt = ST_WASH;
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        w_state_nxt  = ST_FAULT;
                        w_resume_nxt = ST_HEAT;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_WASH: begin
                    if (sig_Completed) begin
                        w_state_nxt = ST_RINSE;
                    end else if (sig_Out_Of_Balance) begin
                        w_state_nxt  = ST_FAULT;
                        w_resume_nxt = ST_WASH;
                    end
                end
                ST_RINSE: begin
                    if (sig_Completed) begin
                        w_rinse_nxt = w_rinse_inc;
                        if (w_rinse_inc == c_RINSE_CYCLES) begin
                            w_state_nxt = ST_SPIN;
                        end
                    end else if (sig_Motor_Failure) begin
                        w_state_nxt  = ST_FAULT;
                        w_resume_nxt = ST_RINSE;
                    end
                end
                ST_SPIN: begin
                    if (sig_Completed) begin
                        w_state_nxt      = ST_IDLE;
                        w_cycle_done_nxt = 1'b1;
                    end else if (sig_Motor_Failure || sig_Out_Of_Balance) begin
                        w_state_nxt  = ST_FAULT;
                        w_resume_nxt = ST_SPIN;
                    end
                end
                ST_FAULT: begin
                    // The acknowledge only counts once the lid is closed again.
                    if (sig_Fault_Ack && sig_Lid_Closed) begin
                        w_retries_nxt = w_retries_inc;
                        if (w_retries_inc == c_MAX_RETRIES) begin
                            w_state_nxt = ST_LOCKOUT;
                        end else begin
                            w_state_nxt = r_resume;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    w_state_nxt = ST_LOCKOUT;
                end
                default: begin
                    // Unused codes recover to IDLE.
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath registers and the registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_resume      <= ST_IDLE;
            r_credit      <= 4'd0;
            r_rinse_cnt   <= 4'd0;
            r_retries     <= 4'd0;
            r_timer       <= '0;
            r_coin_return <= 1'b0;
            r_cycle_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_resume      <= w_resume_nxt;
            r_credit      <= w_credit_nxt;
            r_rinse_cnt   <= w_rinse_nxt;
            r_retries     <= w_retries_nxt;
            r_timer       <= w_timer_nxt;
            r_coin_return <= w_coin_return_nxt;
            r_cycle_done  <= w_cycle_done_nxt;
        end
    end

    assign state                = r_state;
    assign ready                = (r_state == ST_READY);
    assign fill_Water_Operation = (r_state == ST_FILL);
    assign heat_Water_Operation = (r_state == ST_HEAT);
    assign wash_Operation       = (r_state == ST_WASH);
    assign rinse_Operation      = (r_state == ST_RINSE);
    assign spin_Operation       = (r_state == ST_SPIN);
    assign fault                = (r_state == ST_FAULT);
    assign lockout              = (r_state == ST_LOCKOUT);
    assign water_Intake         = (r_state == ST_FILL) || (r_state == ST_RINSE);
    assign coin_Return          = r_coin_return;
    assign cycle_Done           = r_cycle_done;
    assign credit               = r_credit;
    assign rinse_Count          = r_rinse_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wm_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_cycle_controller
// Brief    : Self-checking bench for wm_cycle_controller: a vector table plus
//            hand-written timeout and lockout sequences, with the expected
//            values queued when each stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_cycle_controller;

    localparam int unsigned COIN_PRICE     = 2;
    localparam int unsigned RINSE_CYCLES   = 3;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned MAX_RETRIES    = 2;

    // Input bit positions within a stimulus word.
    localparam logic [9:0] I_C = 10'h001;  // coin
    localparam logic [9:0] I_X = 10'h002;  // cancel
    localparam logic [9:0] I_L = 10'h004;  // lid closed
    localparam logic [9:0] I_F = 10'h008;  // full
    localparam logic [9:0] I_T = 10'h010;  // temperature
    localparam logic [9:0] I_P = 10'h020;  // completed
    localparam logic [9:0] I_O = 10'h040;  // out of balance
    localparam logic [9:0] I_M = 10'h080;  // motor failure
    localparam logic [9:0] I_A = 10'h100;  // fault ack
    localparam logic [9:0] I_R = 10'h200;  // reset

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sig_Coin = 1'b0, sig_Cancel = 1'b0, sig_Lid_Closed = 1'b0;
    logic       sig_Full = 1'b0, sig_Temperature = 1'b0, sig_Completed = 1'b0;
    logic       sig_Out_Of_Balance = 1'b0, sig_Motor_Failure = 1'b0, sig_Fault_Ack = 1'b0;
    logic [3:0] state, credit, rinse_Count;
    logic       ready, fill_Water_Operation, heat_Water_Operation, wash_Operation;
    logic       rinse_Operation, spin_Operation, fault, lockout, water_Intake;
    logic       coin_Return, cycle_Done;

    wm_cycle_controller #(
        .COIN_PRICE    (COIN_PRICE),
        .RINSE_CYCLES  (RINSE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .sig_Coin            (sig_Coin),
        .sig_Cancel          (sig_Cancel),
        .sig_Lid_Closed      (sig_Lid_Closed),
        .sig_Full            (sig_Full),
        .sig_Temperature     (sig_Temperature),
        .sig_Completed       (sig_Completed),
        .sig_Out_Of_Balance  (sig_Out_Of_Balance),
        .sig_Motor_Failure   (sig_Motor_Failure),
        .sig_Fault_Ack       (sig_Fault_Ack),
        .state               (state),
        .ready               (ready),
        .fill_Water_Operation(fill_Water_Operation),
        .heat_Water_Operation(heat_Water_Operation),
        .wash_Operation      (wash_Operation),
        .rinse_Operation     (rinse_Operation),
        .spin_Operation      (spin_Operation),
        .fault               (fault),
        .lockout             (lockout),
        .water_Intake        (water_Intake),
        .coin_Return         (coin_Return),
        .cycle_Done          (cycle_Done),
        .credit              (credit),
        .rinse_Count         (rinse_Count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] in;
        logic [3:0] st;
        logic [3:0] cr;
        logic [3:0] rc;
        logic       cret;
        logic       cdone;
    } vec_t;

    typedef struct {
        int         tag;
        logic [3:0] st;
        logic [3:0] cr;
        logic [3:0] rc;
        logic       cret;
        logic       cdone;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    function automatic void v(input logic [9:0] in, input logic [3:0] st,
                              input logic [3:0] cr, input logic [3:0] rc,
                              input logic cret, input logic cdone);
        vec_t r;
        r.in = in; r.st = st; r.cr = cr; r.rc = rc; r.cret = cret; r.cdone = cdone;
        tbl.push_back(r);
    endfunction

    // Expected {ready, fill, heat, wash, rinse, spin, fault, lockout, water}.
    function automatic logic [8:0] dec(input logic [3:0] st);
        case (st)
            4'd1:    dec = 9'b1_0000_0000;
            4'd2:    dec = 9'b0_1000_0001;
            4'd3:    dec = 9'b0_0100_0000;
            4'd4:    dec = 9'b0_0010_0000;
            4'd5:    dec = 9'b0_0001_0001;
            4'd6:    dec = 9'b0_0000_1000;
            4'd7:    dec = 9'b0_0000_0100;
            4'd8:    dec = 9'b0_0000_0010;
            default: dec = 9'b0_0000_0000;
        endcase
    endfunction

    task automatic cmp(input string nm, input int t, input logic [15:0] act,
                       input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h want=%0h", nm, t, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard step=%0d got=empty want=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        cmp("state",       e.tag, 16'(state),       16'(e.st));
        cmp("credit",      e.tag, 16'(credit),      16'(e.cr));
        cmp("rinse_Count", e.tag, 16'(rinse_Count), 16'(e.rc));
        cmp("coin_Return", e.tag, 16'(coin_Return), 16'(e.cret));
        cmp("cycle_Done",  e.tag, 16'(cycle_Done),  16'(e.cdone));
        cmp("decodes",     e.tag,
            16'({ready, fill_Water_Operation, heat_Water_Operation, wash_Operation,
                 rinse_Operation, spin_Operation, fault, lockout, water_Intake}),
            16'(dec(e.st)));
    endtask

    // Drive one cycle of inputs, queue its expectation, and check after the edge.
    task automatic step(input logic [9:0] in, input logic [3:0] st,
                        input logic [3:0] cr, input logic [3:0] rc,
                        input logic cret, input logic cdone);
        exp_t e;
        sig_Coin           = in[0];
        sig_Cancel         = in[1];
        sig_Lid_Closed     = in[2];
        sig_Full           = in[3];
        sig_Temperature    = in[4];
        sig_Completed      = in[5];
        sig_Out_Of_Balance = in[6];
        sig_Motor_Failure  = in[7];
        sig_Fault_Ack      = in[8];
        reset              = in[9];
        e.tag = tag; e.st = st; e.cr = cr; e.rc = rc; e.cret = cret; e.cdone = cdone;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check_out();
        tag++;
    endtask

    initial begin
        // Credit, cancel and refund behaviour.
        v(I_R,       0, 0, 0, 0, 0);
        v(I_C,       0, 1, 0, 0, 0);
        v(I_X | I_C, 0, 0, 0, 1, 0);  // cancel beats the same-cycle coin
        v(0,         0, 0, 0, 0, 0);  // refund pulse lasts one cycle
        v(I_X,       0, 0, 0, 0, 0);  // nothing to refund
        v(I_C,       0, 1, 0, 0, 0);
        v(I_C,       1, 2, 0, 0, 0);
        v(I_C,       1, 2, 0, 0, 0);  // saturated in READY
        v(I_X | I_L, 0, 0, 0, 1, 0);  // cancel beats lid in READY
        v(0,         0, 0, 0, 0, 0);
        // Reset in HEAT.
        v(I_C,       0, 1, 0, 0, 0);
        v(I_C,       1, 2, 0, 0, 0);
        v(I_L,       2, 0, 0, 0, 0);
        v(I_L | I_F, 3, 0, 0, 0, 0);
        v(I_R | I_L, 0, 0, 0, 0, 0);
        // Full wash with one WASH fault and resume.
        v(I_C,       0, 1, 0, 0, 0);
        v(I_C,       1, 2, 0, 0, 0);
        v(I_L,       2, 0, 0, 0, 0);
        v(I_L | I_F, 3, 0, 0, 0, 0);
        v(I_L | I_T, 4, 0, 0, 0, 0);
        v(I_L | I_O, 7, 0, 0, 0, 0);
        v(I_A,       7, 0, 0, 0, 0);  // ack ignored while lid open
        v(I_L | I_A, 4, 0, 0, 0, 0);
        v(I_L | I_O | I_P, 5, 0, 0, 0, 0);  // completion beats fault
        v(I_L | I_P, 5, 0, 1, 0, 0);
        v(I_L | I_P, 5, 0, 2, 0, 0);
        v(I_L | I_P, 6, 0, 3, 0, 0);
        v(I_L | I_P, 0, 0, 3, 0, 1);
        v(0,         0, 0, 3, 0, 0);
        // Two WASH faults exhaust the retries.
        v(I_C,       0, 1, 3, 0, 0);
        v(I_C,       1, 2, 3, 0, 0);
        v(I_L,       2, 0, 0, 0, 0);
        v(I_L | I_F, 3, 0, 0, 0, 0);
        v(I_L | I_T, 4, 0, 0, 0, 0);
        v(I_L | I_O, 7, 0, 0, 0, 0);
        v(I_L | I_A, 4, 0, 0, 0, 0);
        v(I_L | I_O, 7, 0, 0, 0, 0);
        v(I_L | I_A, 8, 0, 0, 0, 0);
        v(I_C | I_X | I_L | I_A | I_P, 8, 0, 0, 0, 0);
        v(I_L | I_F | I_T | I_M, 8, 0, 0, 0, 0);
        v(I_R,       0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].st, tbl[i].cr, tbl[i].rc, tbl[i].cret, tbl[i].cdone);
        end

        // FILL timeout, resume with a fresh timer, and a lid-open SPIN.
        step(I_R, 0, 0, 0, 0, 0);
        step(I_C, 0, 1, 0, 0, 0);
        step(I_C, 1, 2, 0, 0, 0);
        step(I_L, 2, 0, 0, 0, 0);
        for (int k = 0; k < int'(TIMEOUT_CYCLES) - 1; k++) step(I_L, 2, 0, 0, 0, 0);
        step(I_L, 7, 0, 0, 0, 0);          // 8th clock in FILL
        step(I_L | I_A, 2, 0, 0, 0, 0);
        for (int k = 0; k < int'(TIMEOUT_CYCLES) - 1; k++) step(I_L, 2, 0, 0, 0, 0);
        step(I_L | I_F, 3, 0, 0, 0, 0);    // timer restarted from zero
        step(I_L | I_T, 4, 0, 0, 0, 0);
        step(I_L | I_P, 5, 0, 0, 0, 0);
        step(I_L | I_P, 5, 0, 1, 0, 0);
        step(I_L | I_P, 5, 0, 2, 0, 0);
        step(I_L | I_P | I_M, 6, 0, 3, 0, 0);
        step(I_P, 7, 0, 3, 0, 0);          // lid open beats completion
        step(I_L | I_A, 8, 0, 3, 0, 0);    // second ack of this wash
        step(I_C | I_L, 8, 0, 3, 0, 0);
        step(I_R, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
